alu_cmd_sequencer: RTL

Command-side initiator for the team's 8-bit combinational ALU, which uses a 3-bit opcode with operands A and B.
- Accepts register-level commands over a valid/ready interface and reads operands from an internal 4x8 register file.
- Drives the ALU operand and opcode lines, samples the ALU result after a programmable latency, writes it back, and returns it on a valid/ready response channel.
- Sits between the control logic and the ALU instance.

---
 rtl/alu_seq_pkg.sv | 36 +++
 rtl/alu_seq_regfile.sv | 38 +++
 rtl/alu_cmd_sequencer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU command sequencer: widths, opcodes,
// FSM state encoding and the response payload layout.
package alu_seq_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned OP_W      = 3;
  localparam int unsigned REG_IDX_W = 2;
  localparam int unsigned NREG      = 4;
  localparam int unsigned CNT_W     = 3;

  localparam logic [OP_W-1:0] OP_NOT  = 3'b000;
  localparam logic [OP_W-1:0] OP_OR   = 3'b001;
  localparam logic [OP_W-1:0] OP_XOR  = 3'b010;
  localparam logic [OP_W-1:0] OP_AND  = 3'b011;
  localparam logic [OP_W-1:0] OP_MUL  = 3'b100;
  localparam logic [OP_W-1:0] OP_ADD  = 3'b101;
  localparam logic [OP_W-1:0] OP_SUB  = 3'b110;
  localparam logic [OP_W-1:0] OP_ZERO = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [DATA_W-1:0]    data;
  } rsp_t;

  // {N, Z} status flags of a result value
  function automatic logic [1:0] flags_of(input logic [DATA_W-1:0] d);
    return {d[DATA_W-1], (d == '0)};
  endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// 4x8 register file: two asynchronous read ports, one synchronous write port,
// synchronous active-high reset clears every entry.
// Ports:
//   clk_i, rst_i            clock / synchronous reset
//   raddr_a_i, rdata_a_o    read port A
//   raddr_b_i, rdata_b_o    read port B
//   we_i, waddr_i, wdata_i  write port
module alu_seq_regfile
  import alu_seq_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [REG_IDX_W-1:0] raddr_a_i,
  output logic [DATA_W-1:0]    rdata_a_o,
  input  logic [REG_IDX_W-1:0] raddr_b_i,
  output logic [DATA_W-1:0]    rdata_b_o,
  input  logic                 we_i,
  input  logic [REG_IDX_W-1:0] waddr_i,
  input  logic [DATA_W-1:0]    wdata_i
);

  logic [DATA_W-1:0] regs_q [NREG];

  // Storage with synchronous clear
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = regs_q[raddr_a_i];
  assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command-side initiator for the 8-bit combinational ALU. Accepts one
// register-level command at a time, drives the ALU operands/opcode, samples
// the result ALU_LAT cycles later, writes it back and returns it on a
// valid/ready response channel. Loads bypass the ALU.
// Ports:
//   clk, rst                       clock / synchronous active-high reset
//   cmd_valid, cmd_ready           command handshake (cmd_ready high in IDLE)
//   cmd_op, cmd_load, cmd_use_imm  command kind
//   cmd_ra, cmd_rb, cmd_rd         register indices
//   cmd_imm                        immediate
//   alu_a, alu_b, alu_opcode       ALU inputs (opcode 111 outside ISSUE)
//   alu_result                     ALU output
//   rsp_valid, rsp_ready           response handshake
//   rsp_data, rsp_rd               written-back value and its destination
//   rsp_flags                      {N, Z}, present only with ALU_FLAGS_EN
// Optional feature macro: ALU_FLAGS_EN
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned ALU_LAT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [OP_W-1:0]      cmd_op,
  input  logic                 cmd_load,
  input  logic                 cmd_use_imm,
  input  logic [REG_IDX_W-1:0] cmd_ra,
  input  logic [REG_IDX_W-1:0] cmd_rb,
  input  logic [REG_IDX_W-1:0] cmd_rd,
  input  logic [DATA_W-1:0]    cmd_imm,
  output logic [DATA_W-1:0]    alu_a,
  output logic [DATA_W-1:0]    alu_b,
  output logic [OP_W-1:0]      alu_opcode,
  input  logic [DATA_W-1:0]    alu_result,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_W-1:0]    rsp_data,
  output logic [REG_IDX_W-1:0] rsp_rd
`ifdef ALU_FLAGS_EN
  ,
  output logic [1:0]           rsp_flags
`endif
);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [REG_IDX_W-1:0]  rd_q, rd_d;
  logic [DATA_W-1:0]     alu_a_q, alu_a_d;
  logic [DATA_W-1:0]     alu_b_q, alu_b_d;
  logic [OP_W-1:0]       alu_op_q, alu_op_d;
  logic                  rsp_valid_q, rsp_valid_d;
  rsp_t                  rsp_q, rsp_d;

  logic                  rf_we;
  logic [REG_IDX_W-1:0]  rf_waddr;
  logic [DATA_W-1:0]     rf_wdata;
  logic [DATA_W-1:0]     rf_rdata_a;
  logic [DATA_W-1:0]     rf_rdata_b;

  // Read ports follow the live command so operands are ready at accept
  alu_seq_regfile u_regfile (
    .clk_i     (clk),
    .rst_i     (rst),
    .raddr_a_i (cmd_ra),
    .rdata_a_o (rf_rdata_a),
    .raddr_b_i (cmd_rb),
    .rdata_b_o (rf_rdata_b),
    .we_i      (rf_we),
    .waddr_i   (rf_waddr),
    .wdata_i   (rf_wdata)
  );

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rd_q        <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= OP_ZERO;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
    end
  end

  // Next-state and datapath control; writeback fires on every entry to RESP
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_d        = rd_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    rsp_valid_d = rsp_valid_q;
    rsp_d       = rsp_q;
    rf_we       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_load) begin
            state_d      = ST_RESP;
            rsp_valid_d  = 1'b1;
            rsp_d.rd     = cmd_rd;
            rsp_d.data   = cmd_imm;
            rf_we        = 1'b1;
          end else begin
            state_d  = ST_ISSUE;
            rd_d     = cmd_rd;
            alu_a_d  = rf_rdata_a;
            alu_b_d  = cmd_use_imm ? cmd_imm : rf_rdata_b;
            alu_op_d = cmd_op;
            cnt_d    = '0;
          end
        end
      end
      ST_ISSUE: begin
        if (cnt_q == CNT_W'(ALU_LAT)) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_d.rd    = rd_q;
          rsp_d.data  = alu_result;
          rf_we       = 1'b1;
          alu_op_d    = OP_ZERO;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign rf_waddr   = rsp_d.rd;
  assign rf_wdata   = rsp_d.data;

  assign cmd_ready  = (state_q == ST_IDLE);
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = alu_op_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_q.data;
  assign rsp_rd     = rsp_q.rd;

`ifdef ALU_FLAGS_EN
  logic [1:0] flags_q, flags_d;

  // Flags track the value being written back, loads included
  always_comb begin
    flags_d = flags_q;
    if (rf_we) begin
      flags_d = flags_of(rf_wdata);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= 2'b00;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign rsp_flags = flags_q;
`endif

endmodule
